// File: rtl/ysyx_040066_defs.sv
// Shared CLINT definitions: register offsets, interrupt causes, CSR bit indices
// and the byte-masked merge used by every writable register.
package ysyx_040066_defs;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [63:0] CAUSE_MSI = 64'h8000_0000_0000_0003;
  localparam logic [63:0] CAUSE_MTI = 64'h8000_0000_0000_0007;

  localparam int unsigned MSTATUS_MIE = 3;
  localparam int unsigned MIE_MSIE    = 3;
  localparam int unsigned MIE_MTIE    = 7;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_t;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_PEND
  } irq_state_t;

  typedef enum logic [1:0] {
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME,
    SEL_NONE
  } reg_sel_t;

  function automatic reg_sel_t decode(input logic [15:0] off);
    reg_sel_t sel;
    case (off)
      MSIP_OFF:     sel = SEL_MSIP;
      MTIMECMP_OFF: sel = SEL_MTIMECMP;
      MTIME_OFF:    sel = SEL_MTIME;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] old,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wmask);
    logic [63:0] r;
    r = old;
    for (int unsigned i = 0; i < 8; i++) begin
      if (wmask[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx_040066_clint_if.sv
// Device-bus request/response channel between a master and the CLINT.
interface ysyx_040066_clint_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_040066_clint_timer.sv
// mtime/mtimecmp with prescaler and registered mtip; byte-masked write ports.
module ysyx_040066_clint_timer
  import ysyx_040066_defs::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtime_we,
  input  logic        mtimecmp_we,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      div_cnt  <= '0;
      mtip     <= 1'b0;
    end else begin
      // A bus write to mtime overrides the tick and restarts the prescaler.
      if (mtime_we) begin
        mtime   <= byte_merge(mtime, wdata, wmask);
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        mtime   <= mtime + 64'd1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
      if (mtimecmp_we) mtimecmp <= byte_merge(mtimecmp, wdata, wmask);
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/ysyx_040066_clint.sv
// Core-local interruptor: bus slave for msip/mtimecmp/mtime and the registered
// interrupt request presented to the pipeline.
module ysyx_040066_clint
  import ysyx_040066_defs::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_040066_clint_if.slave   bus,
  input  logic [63:0]          mie,
  input  logic [63:0]          mstatus,
  output logic                 irq_valid,
  output logic [63:0]          irq_cause,
  input  logic                 irq_ack,
  output logic                 mtip,
  output logic                 msip_o
);

  bus_state_t  bus_state;
  irq_state_t  irq_state;
  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] off;
  reg_sel_t    sel;
  logic        accept;
  logic        wr;
  logic        mtime_we;
  logic        mtimecmp_we;
  logic        msip_we;
  logic [63:0] rd_value;
  logic        sw_pend;
  logic        tm_pend;
  logic        pend;
  logic        unused_csr_bits;

  assign off         = bus.req_addr - BASE_ADDR;
  assign sel         = decode(off);
  assign accept      = (bus_state == BUS_IDLE) && bus.req_valid;
  assign wr          = accept && bus.req_we;
  assign mtime_we    = wr && (sel == SEL_MTIME);
  assign mtimecmp_we = wr && (sel == SEL_MTIMECMP);
  assign msip_we     = wr && (sel == SEL_MSIP) && bus.req_wmask[0];

  always_comb begin
    rd_value = '0;
    case (sel)
      SEL_MSIP:     rd_value = {63'd0, msip};
      SEL_MTIMECMP: rd_value = mtimecmp;
      SEL_MTIME:    rd_value = mtime;
      default:      rd_value = '0;
    endcase
  end

  ysyx_040066_clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .mtime_we   (mtime_we),
    .mtimecmp_we(mtimecmp_we),
    .wdata      (bus.req_wdata),
    .wmask      (bus.req_wmask),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .mtip       (mtip)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_state       <= BUS_IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      msip            <= 1'b0;
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          if (bus.req_valid) begin
            bus_state      <= BUS_RESP;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= bus.req_we ? '0 : rd_value;
            bus.resp_err   <= (sel == SEL_NONE);
            if (msip_we) msip <= bus.req_wdata[0];
          end
        end
        BUS_RESP: begin
          if (bus.resp_ready) begin
            bus_state      <= BUS_IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
          end
        end
        default: bus_state <= BUS_IDLE;
      endcase
    end
  end

  assign msip_o  = msip;
  assign sw_pend = msip & mie[MIE_MSIE];
  assign tm_pend = mtip & mie[MIE_MTIE];
  assign pend    = mstatus[MSTATUS_MIE] & (sw_pend | tm_pend);

  // Cause is latched on rise and held; dropping to IDLE on ack guarantees
  // at least one idle cycle before the next request can rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_state <= IRQ_IDLE;
      irq_valid <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (irq_state)
        IRQ_IDLE: begin
          if (pend) begin
            irq_state <= IRQ_PEND;
            irq_valid <= 1'b1;
            irq_cause <= sw_pend ? CAUSE_MSI : CAUSE_MTI;
          end
        end
        IRQ_PEND: begin
          if (irq_ack || !pend) begin
            irq_state <= IRQ_IDLE;
            irq_valid <= 1'b0;
          end
        end
        default: irq_state <= IRQ_IDLE;
      endcase
    end
  end

  assign unused_csr_bits = ^{mie[63:8], mie[6:4], mie[2:0],
                             mstatus[63:4], mstatus[2:0]};

endmodule

// File: tb/tb_ysyx_040066_clint.sv
// Directed checks of the CLINT bus map, timer, interrupt handshake and reset.
module tb_ysyx_040066_clint;
  import ysyx_040066_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mie;
  logic [63:0] mstatus;
  logic        irq_valid;
  logic [63:0] irq_cause;
  logic        irq_ack;
  logic        mtip;
  logic        msip_o;
  logic [63:0] rd;
  logic        err;

  int total = 0;
  int bad   = 0;

  ysyx_040066_clint_if bus ();

  ysyx_040066_clint #(
    .TICK_DIV (1),
    .BASE_ADDR(16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mie      (mie),
    .mstatus  (mstatus),
    .irq_valid(irq_valid),
    .irq_cause(irq_cause),
    .irq_ack  (irq_ack),
    .mtip     (mtip),
    .msip_o   (msip_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_txn(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, output logic [63:0] rdata, output logic rerr);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    step;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    check("resp_valid_latency", 64'(bus.resp_valid), 64'd1);
    rdata = bus.resp_rdata;
    rerr  = bus.resp_err;
    step;
    check("resp_retire", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    rst            = 1'b0;
    mie            = '0;
    mstatus        = '0;
    irq_ack        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b1;
    step;
    step;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_irq_valid", 64'(irq_valid), 64'd0);
    check("rst_irq_cause", irq_cause, 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    check("rst_msip", 64'(msip_o), 64'd0);

    // mtime counts one per edge after reset release; read sees pre-increment value
    rst = 1'b1;
    repeat (10) step;
    bus_txn(1'b0, MTIME_OFF, '0, 8'h00, rd, err);
    check("mtime_after_10", rd, 64'd10);
    check("mtime_read_err", 64'(err), 64'd0);

    // timer interrupt path
    mie     = 64'h80;
    mstatus = 64'h8;
    bus_txn(1'b1, MTIMECMP_OFF, 64'd20, 8'hFF, rd, err);
    check("write_rdata_zero", rd, 64'd0);
    check("write_err", 64'(err), 64'd0);
    bus_txn(1'b1, MTIME_OFF, 64'd10, 8'hFF, rd, err);
    repeat (9) step;
    check("mtip_before_20", 64'(mtip), 64'd0);
    step;
    check("mtip_rise", 64'(mtip), 64'd1);
    check("irq_not_yet", 64'(irq_valid), 64'd0);
    step;
    check("irq_timer_valid", 64'(irq_valid), 64'd1);
    check("irq_timer_cause", irq_cause, 64'h8000_0000_0000_0007);

    // software interrupt priority, hold, ack and idle gap
    mie = 64'h88;
    bus_txn(1'b1, MSIP_OFF, 64'd1, 8'h01, rd, err);
    check("msip_set", 64'(msip_o), 64'd1);
    check("cause_held", irq_cause, 64'h8000_0000_0000_0007);
    irq_ack = 1'b1;
    step;
    irq_ack = 1'b0;
    check("ack_drop", 64'(irq_valid), 64'd0);
    step;
    check("sw_valid", 64'(irq_valid), 64'd1);
    check("sw_cause", irq_cause, 64'h8000_0000_0000_0003);
    bus_txn(1'b1, MSIP_OFF, 64'd0, 8'h01, rd, err);
    check("msip_clear", 64'(msip_o), 64'd0);
    check("sw_cause_held", irq_cause, 64'h8000_0000_0000_0003);
    irq_ack = 1'b1;
    step;
    irq_ack = 1'b0;
    check("ack2_drop", 64'(irq_valid), 64'd0);
    step;
    check("tm_again_valid", 64'(irq_valid), 64'd1);
    check("tm_again_cause", irq_cause, 64'h8000_0000_0000_0007);
    mstatus = '0;
    step;
    check("cond_gone_drop", 64'(irq_valid), 64'd0);

    // mtime wrap and mtip recompute
    bus_txn(1'b1, MTIME_OFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, err);
    check("mtip_high_time", 64'(mtip), 64'd1);
    step;
    bus_txn(1'b0, MTIME_OFF, '0, 8'h00, rd, err);
    check("mtime_wrap", rd, 64'd0);
    check("mtip_after_wrap", 64'(mtip), 64'd0);

    // byte mask on reset-valued mtimecmp, msip upper bits
    rst = 1'b0;
    step;
    rst = 1'b1;
    bus_txn(1'b1, MTIMECMP_OFF, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, rd, err);
    bus_txn(1'b0, MTIMECMP_OFF, '0, 8'h00, rd, err);
    check("mtimecmp_masked", rd, 64'hFFFF_FFFF_CCCC_DDDD);
    bus_txn(1'b1, MSIP_OFF, '1, 8'hFF, rd, err);
    bus_txn(1'b0, MSIP_OFF, '0, 8'h00, rd, err);
    check("msip_read", rd, 64'd1);

    // unmapped read, response backpressure, reset during RESP
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 16'h1234;
    step;
    bus.req_valid = 1'b0;
    check("bad_valid", 64'(bus.resp_valid), 64'd1);
    check("bad_err", 64'(bus.resp_err), 64'd1);
    check("bad_rdata", bus.resp_rdata, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      check("hold_valid", 64'(bus.resp_valid), 64'd1);
      check("hold_not_ready", 64'(bus.req_ready), 64'd0);
    end
    rst = 1'b0;
    step;
    check("rst_resp_drop", 64'(bus.resp_valid), 64'd0);
    check("rst_req_ready2", 64'(bus.req_ready), 64'd1);
    rst            = 1'b1;
    bus.resp_ready = 1'b1;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040066_clint.md
Name: ysyx_040066_clint

Overview:
Core-local interruptor on the memory-mapped device bus. It owns mtime, mtimecmp and msip, and derives the machine timer and software pending bits from them. It turns the CSR file's mie/mstatus outputs into a registered interrupt request (valid, cause) that the pipeline consumes. This block is the source end of the CSR file's raise_intr/NO/clear_mip path.

Parameters:
TICK_DIV, 1, number of clk cycles per mtime increment (must be >=1).
BASE_ADDR, 16'h0000, offset subtracted from addr before register decode.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
req_valid  in  1  bus request valid.
req_ready  out  1  bus request accepted this cycle.
req_we  in  1  1=write, 0=read.
req_addr  in  16  byte address.
req_wdata  in  64  write data.
req_wmask  in  8  byte enables for writes.
resp_valid  out  1  read/write response valid.
resp_ready  in  1  master accepts response.
resp_rdata  out  64  read data (0 for writes).
resp_err  out  1  unmapped address.
mie  in  64  from CSR file.
mstatus  in  64  from CSR file.
irq_valid  out  1  interrupt request to pipeline.
irq_cause  out  64  value for CSR NO input.
irq_ack  in  1  pipeline took the trap this cycle.
mtip  out  1  timer pending, to CSR mip mirror.
msip_o  out  1  software pending.

Behaviour:
- Reset (rst==0 at a posedge): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, div counter=0, FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, irq_valid=0, irq_cause=0, mtip=0. Reset during RESP drops the response and returns to IDLE.
- Map (addr-BASE_ADDR): 16'h0000 msip (bit0 only, upper bits read 0), 16'h4000 mtimecmp, 16'hBFF8 mtime. Any other offset: write ignored, rdata=0, resp_err=1.
- Bus FSM IDLE/RESP. IDLE: req_ready=1. On req_valid, the request is accepted, the write is performed at that edge, the read value is captured, and the FSM moves to RESP. RESP: req_ready=0, resp_valid=1, and outputs are held until resp_ready. Then the FSM returns to IDLE. One outstanding request; latency is 1 cycle from accept to resp_valid.
- Byte mask: only masked bytes are updated. A read of mtime returns the pre-increment value at the accept edge.
- mtime: increments when div counter == TICK_DIV-1, and the counter wraps to 0. A bus write to mtime in the same cycle wins: no increment, and the counter is cleared. mtime wraps 2^64-1 -> 0.
- mtip is registered: mtip <= (mtime >= mtimecmp), unsigned, using the current register values. It updates one cycle after any change.
- Pending: sw = msip & mie[3]; tm = mtip & mie[7]; en = mstatus[3].
- irq FSM:
  - When irq_valid==0 and en&(sw|tm), next cycle irq_valid=1.
  - irq_cause = {1'b1,63'd3} if sw, else {1'b1,63'd7}. Software has priority over timer.
  - irq_valid and irq_cause are held stable while valid; the request condition is not re-sampled.
  - On irq_ack, irq_valid=0 at the next edge. A new request cannot rise in the same cycle as the ack (at least one idle cycle).
  - If the condition disappears while irq_valid==1 and no ack arrives, irq_valid is dropped the next cycle.
  - irq_ack while irq_valid==0 is ignored.
- msip_o mirrors the msip register.

Decomposition:
- Shared package (ysyx_040066_defs): CLINT offsets (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), cause codes (CAUSE_MSI=64'h8000_0000_0000_0003, CAUSE_MTI=64'h8000_0000_0000_0007), mstatus.MIE bit index 3, mie.MSIE=3, mie.MTIE=7.
- One sub-module: ysyx_040066_clint_timer. It holds the prescaler, mtime, mtimecmp, the mtip register and the byte-masked write ports. The top keeps the bus FSM, msip and the irq FSM.

Test Plan:
- Reset, then read 0xBFF8 at TICK_DIV=1 after 10 idle cycles -> resp_valid one cycle after accept, rdata=10 (+/-0 by the documented sample point), resp_err=0.
- Write mtimecmp=20, mie=0x80, mstatus=0x8 -> mtip rises the cycle after mtime reaches 20; irq_valid next cycle; irq_cause=0x8000_0000_0000_0007.
- Write msip=1 with mie=0x88 and mtip=1 -> irq_cause=...0003. Ack, clear msip -> after one idle cycle irq_valid=1 with cause ...0007.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE and let 2 ticks pass -> reads 0; mtip recomputed (mtimecmp=20 -> mtip=0).
- Write with wmask=8'h0F of 64'hAAAA_BBBB_CCCC_DDDD to mtimecmp (reset value) -> read 64'hFFFF_FFFF_CCCC_DDDD.
- Read 0x1234 -> resp_err=1, rdata=0. Hold resp_ready=0 for 3 cycles -> resp_valid held and req_ready=0. Assert rst=0 mid-RESP -> resp_valid=0 and req_ready=1 next cycle.
